// File: rtl/uart_rx_16x_if.sv
// Byte-side handshake between uart_rx_16x (master) and the UART register logic (slave).
// With UART_RX_PARITY_EN defined it also carries the parity controls and parity_err.
interface uart_rx_16x_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ack;
    logic       framing_err;
    logic       overrun;
`ifdef UART_RX_PARITY_EN
    logic       parity_en;
    logic       parity_odd;
    logic       parity_err;

    modport master (
        output rx_data, rx_valid, framing_err, overrun, parity_err,
        input  rx_ack, parity_en, parity_odd
    );
    modport slave (
        input  rx_data, rx_valid, framing_err, overrun, parity_err,
        output rx_ack, parity_en, parity_odd
    );
`else
    modport master (
        output rx_data, rx_valid, framing_err, overrun,
        input  rx_ack
    );
    modport slave (
        input  rx_data, rx_valid, framing_err, overrun,
        output rx_ack
    );
`endif
endinterface

// File: rtl/uart_rx_16x.sv
// 16x-oversampling UART receiver clocked by clk_50m; the 1.8432 MHz reference is sampled as data.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx_16x #(
    parameter int DATA_BITS   = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk_50m,
    input  logic          rst_n,
    input  logic          clk_1p8432m,
    input  logic [15:0]   divisor,
    input  logic          rxd,
    uart_rx_16x_if.master rx_if
);
    localparam logic [2:0] LAST_BIT    = 3'(DATA_BITS - 1);
    localparam int         ALIGN_SHIFT = 8 - DATA_BITS;

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK_WAIT
`ifdef UART_RX_PARITY_EN
        , PARITY
`endif
    } state_e;

    logic [SYNC_STAGES-1:0] ref_sync_q, ref_sync_d;
    logic [SYNC_STAGES-1:0] rxd_sync_q, rxd_sync_d;
    logic                   ref_last_q, ref_last_d;
    logic [15:0]            div_cnt_q, div_cnt_d;
    logic                   ref_en, tick16, rxd_s, sample, load;

    state_e     state_q, state_d;
    logic [3:0] scnt_q, scnt_d;
    logic [2:0] bcnt_q, bcnt_d;
    logic [7:0] shift_q, shift_d, data_aligned;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       framing_err_q, framing_err_d;
    logic       overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic       par_en_q, par_en_d, par_odd_q, par_odd_d;
    logic       par_bit_q, par_bit_d, parity_err_q, parity_err_d;
`endif

    // NOTE: every signal written in an always_comb gets a default first; a missing branch would otherwise infer a latch.
    always_comb begin
        ref_sync_d = {ref_sync_q[SYNC_STAGES-2:0], clk_1p8432m};
        rxd_sync_d = {rxd_sync_q[SYNC_STAGES-2:0], rxd};
        rxd_s      = rxd_sync_q[SYNC_STAGES-1];
        ref_last_d = ref_sync_q[SYNC_STAGES-1];
        ref_en     = ref_sync_q[SYNC_STAGES-1] & ~ref_last_q;
        div_cnt_d  = div_cnt_q;
        tick16     = 1'b0;
        if (ref_en) begin
            div_cnt_d = (div_cnt_q <= 16'd1) ? divisor : div_cnt_q - 16'd1;
            // A zero divisor must never tick, even while a stale count drains through 1.
            tick16    = (divisor != 16'd0) && ((div_cnt_q == 16'd1) || (divisor == 16'd1));
        end
    end

    // NOTE: sequential state uses <= so every flop sees pre-edge values; = would make results depend on block order.
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            ref_sync_q <= '0;
            rxd_sync_q <= '1;
            ref_last_q <= 1'b0;
            div_cnt_q  <= '0;
        end else begin
            ref_sync_q <= ref_sync_d;
            rxd_sync_q <= rxd_sync_d;
            ref_last_q <= ref_last_d;
            div_cnt_q  <= div_cnt_d;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bcnt_d  = bcnt_q;
        if (tick16) begin
            case (state_q)
                IDLE: if (!rxd_s) begin
                    state_d = START;
                    scnt_d  = '0;
                end
                START: if (scnt_q == 4'd7) begin
                    state_d = rxd_s ? IDLE : DATA;
                    scnt_d  = '0;
                    bcnt_d  = '0;
                end else begin
                    scnt_d = scnt_q + 4'd1;
                end
                DATA: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) begin
                        bcnt_d = bcnt_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                        if (bcnt_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
`else
                        if (bcnt_q == LAST_BIT) state_d = STOP;
`endif
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) state_d = STOP;
                end
`endif
                STOP: begin
                    scnt_d = scnt_q + 4'd1;
                    if (scnt_q == 4'd15) state_d = rxd_s ? IDLE : BRK_WAIT;
                end
                BRK_WAIT: if (rxd_s) state_d = IDLE;
                default:  state_d = IDLE;
            endcase
        end
    end

    assign sample = tick16 && (scnt_q == 4'd15);

    always_comb begin
        shift_d       = shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        framing_err_d = framing_err_q;
        overrun_d     = overrun_q;
        data_aligned  = shift_q >> ALIGN_SHIFT;
        load          = sample && (state_q == STOP);
        if (sample && (state_q == DATA)) shift_d = {rxd_s, shift_q[7:1]};
`ifdef UART_RX_PARITY_EN
        par_en_d     = par_en_q;
        par_odd_d    = par_odd_q;
        par_bit_d    = par_bit_q;
        parity_err_d = parity_err_q;
        if (tick16 && (state_q == START) && (scnt_q == 4'd7) && !rxd_s) begin
            par_en_d  = rx_if.parity_en;
            par_odd_d = rx_if.parity_odd;
        end
        if (sample && (state_q == PARITY)) par_bit_d = rxd_s;
        if (load) parity_err_d = par_en_q && (((^data_aligned) ^ par_bit_q) != par_odd_q);
`endif
        if (load) begin
            rx_data_d     = data_aligned;
            rx_valid_d    = 1'b1;
            framing_err_d = ~rxd_s;
            // A simultaneous ack consumes the old byte, so the overwrite is not an overrun.
            if (!rx_if.rx_ack) overrun_d = overrun_q | rx_valid_q;
        end else if (rx_if.rx_ack && rx_valid_q) begin
            rx_valid_d = 1'b0;
            overrun_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            scnt_q        <= '0;
            bcnt_q        <= '0;
            shift_q       <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            framing_err_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            scnt_q        <= scnt_d;
            bcnt_q        <= bcnt_d;
            shift_q       <= shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            framing_err_q <= framing_err_d;
            overrun_q     <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk_50m or negedge rst_n) begin
        if (!rst_n) begin
            par_en_q     <= 1'b0;
            par_odd_q    <= 1'b0;
            par_bit_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_en_q     <= par_en_d;
            par_odd_q    <= par_odd_d;
            par_bit_q    <= par_bit_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign rx_if.parity_err = parity_err_q;
`endif

    assign rx_if.rx_data     = rx_data_q;
    assign rx_if.rx_valid    = rx_valid_q;
    assign rx_if.framing_err = framing_err_q;
    assign rx_if.overrun     = overrun_q;
endmodule

// File: doc/uart_rx_16x.md
Name: uart_rx_16x

Overview:
UART receiver for the 8088 system's serial port. It runs in the clk_50m domain and takes the 1.8432 MHz UART reference clock as a plain input signal, not as a clock. It divides that reference by an 8250-style 16-bit divisor to form a 16x oversampling tick, then deserializes rxd frames (start, DATA_BITS data LSB-first, 1 stop) into a byte with valid/ack handshake and error flags for the bus-side UART register logic.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..8.
SYNC_STAGES, 2, flop stages used to synchronize clk_1p8432m and rxd; minimum 2.

Ports:
clk_50m  input  1  system clock, 50 MHz.
rst_n  input  1  reset.
clk_1p8432m  input  1  1.8432 MHz UART reference, sampled as data.
divisor  input  16  baud divisor; baud = 1.8432 MHz / (16*divisor); 0 disables ticks.
rxd  input  1  serial input; idle high; asynchronous.
rx_data  output  8  received byte; bits above DATA_BITS are 0.
rx_valid  output  1  byte available; level signal, held until ack.
rx_ack  input  1  one-cycle pulse from consumer; clears rx_valid and overrun.
framing_err  output  1  stop bit of the byte in rx_data sampled 0; updated on every load.
overrun  output  1  sticky; a byte was loaded while rx_valid=1.

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk_50m.
- Reset values: rx_data=0, rx_valid=0, framing_err=0, overrun=0, FSM=IDLE, all counters=0, sync flops=1 for rxd and 0 for ref.
- Reference enable: clk_1p8432m passes through SYNC_STAGES flops. A 0->1 edge of the synchronized value gives ref_en, a one-cycle pulse (~1 per 27.1 clk_50m cycles).
- Divisor counter (16 bit):
  - Loaded with divisor on ref_en when the counter is 0 or 1.
  - Otherwise decremented on ref_en.
  - tick16 pulses on the ref_en cycle where the counter is 1, or where divisor=1.
  - A divisor change takes effect at the next reload.
  - divisor=0: no tick16 ever; the FSM holds its state.
- rxd passes through SYNC_STAGES flops to give rxd_s. All FSM decisions are made only on tick16 cycles.
- FSM states: IDLE, START, DATA, STOP, BRK_WAIT. A 4-bit sample counter (scnt) and a 3-bit bit counter (bcnt) drive the transitions.
  - IDLE: rxd_s=0 -> START, scnt=0.
  - START: scnt increments each tick. At scnt=7 (mid start bit):
    - rxd_s=0 -> DATA, scnt=0, bcnt=0.
    - rxd_s=1 -> IDLE (glitch rejected).
  - DATA: at scnt=15, shift rxd_s into the shift register MSB side (LSB-first reception) and increment bcnt. After DATA_BITS bits -> STOP, scnt=0.
  - STOP: at scnt=15, load rx_data (right-aligned, upper bits zero), set rx_valid=1, and set framing_err=~rxd_s.
    - rxd_s=1 -> IDLE.
    - rxd_s=0 -> BRK_WAIT.
  - BRK_WAIT: rxd_s=1 on a tick -> IDLE. No start detection while in this state.
- Latency: rx_valid rises on the clk_50m edge after the tick16 that samples the stop bit.
- Handshake:
  - rx_ack with rx_valid=1 clears rx_valid and overrun next cycle. rx_ack with rx_valid=0 is ignored.
  - Load while rx_valid=1: rx_data is overwritten, overrun=1.
  - Load and rx_ack in the same cycle: load wins. rx_valid stays 1, overrun is unchanged, new data is kept.
- Reset mid-frame: immediate return to reset values; the partial frame is discarded.

Optional Feature:
UART_RX_PARITY_EN:
- Defined:
  - Adds inputs parity_en (1) and parity_odd (1), and output parity_err (1, reset 0).
  - When parity_en=1, a PARITY state sits between DATA and STOP and samples the parity bit at scnt=15.
  - parity_err is set at load to (XOR of data bits ^ parity bit) != parity_odd. It is updated with every load, like framing_err.
  - parity_en and parity_odd are sampled at the start-bit confirm.
- Undefined: ports absent, no PARITY state, frame is start + data + stop only.

Test Plan:
- Bit period reference: divisor=1 gives 115200 baud, 16 ref edges per bit, ~434 clk_50m cycles per bit.
- divisor=1, 8N1 frame 0x55 on rxd -> rx_valid=1 within 1 cycle after the stop sample; rx_data=0x55, framing_err=0, overrun=0.
- divisor=1, rxd low pulse of 150 clk_50m cycles (< half bit) -> FSM returns to IDLE, rx_valid stays 0.
- divisor=1, frame 0xA3 with stop bit 0, rxd then held low 20 bit times before going high -> one load (rx_data=0xA3, framing_err=1), no second frame, next valid frame 0x5A received correctly.
- divisor=1, frames 0x11 then 0x22 with no rx_ack -> rx_data=0x22, overrun=1; rx_ack pulse -> rx_valid=0, overrun=0 next cycle.
- divisor=12 (9600 baud), frame 0xC3 with rst_n pulsed low mid-data -> all outputs 0 immediately; following frame 0x3C gives rx_data=0x3C. Then divisor=0 with a frame on rxd -> no rx_valid.
- With UART_RX_PARITY_EN, DATA_BITS=7, parity_en=1, parity_odd=0, data 0x41 with parity bit 1 -> rx_data=0x41, parity_err=1.
